// File: rtl/trend_predictor_table_pkg.sv
// rtl/trend_predictor_table_pkg.sv - shared trend-counter encodings, step constants and FSM states
package trend_predictor_table_pkg;

    localparam int CNT_W = 3;
    localparam int SUM_W = CNT_W + 1;
    localparam int CLS_W = 4;

    // Bit positions inside the {high_conf, upward, downward, no_conf} class vector
    localparam int CLS_HIGH = 3;
    localparam int CLS_UP   = 2;
    localparam int CLS_DOWN = 1;
    localparam int CLS_NO   = 0;

    localparam logic signed [SUM_W-1:0] STEP_P2 = 4'sd2;
    localparam logic signed [SUM_W-1:0] STEP_P1 = 4'sd1;
    localparam logic signed [SUM_W-1:0] STEP_M2 = -4'sd2;
    localparam logic signed [SUM_W-1:0] STEP_M3 = -4'sd3;

    localparam logic signed [SUM_W-1:0] CNT_MAX = 4'sd3;
    localparam logic signed [SUM_W-1:0] CNT_MIN = -4'sd4;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Classes overlap, so the result is not one-hot
    function automatic logic [CLS_W-1:0] class_of(input logic [CNT_W-1:0] c);
        logic [CLS_W-1:0] cls;
        cls = '0;
        case (c)
            3'b011: cls[CLS_HIGH] = 1'b1;
            3'b010: begin
                cls[CLS_HIGH] = 1'b1;
                cls[CLS_UP]   = 1'b1;
            end
            3'b000: cls[CLS_UP] = 1'b1;
            3'b001, 3'b111: cls[CLS_DOWN] = 1'b1;
            3'b101: begin
                cls[CLS_DOWN] = 1'b1;
                cls[CLS_NO]   = 1'b1;
            end
            default: cls[CLS_NO] = 1'b1;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/trend_predictor_table_step_unit.sv
// rtl/trend_predictor_table_step_unit.sv - class decode and clamped trend-counter step
module trend_step_unit
    import trend_predictor_table_pkg::*;
(
    input  logic [CNT_W-1:0] count,
    input  logic             down,
    output logic [CNT_W-1:0] new_count,
    output logic [CLS_W-1:0] cls
);

    logic signed [SUM_W-1:0] step;
    logic signed [SUM_W-1:0] sum;

    always_comb begin
        cls = class_of(count);
        if (cls[CLS_UP]) begin
            step = down ? STEP_M3 : STEP_P2;
        end else if (cls[CLS_DOWN]) begin
            step = down ? STEP_M2 : STEP_P1;
        end else begin
            step = down ? STEP_M2 : STEP_P2;
        end
        sum = $signed({count[CNT_W-1], count}) + step;
        if (sum > CNT_MAX) begin
            new_count = CNT_MAX[CNT_W-1:0];
        end else if (sum < CNT_MIN) begin
            new_count = CNT_MIN[CNT_W-1:0];
        end else begin
            new_count = sum[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/trend_predictor_table.sv
// rtl/trend_predictor_table.sv - trend-counter direction predictor table with misprediction statistic
module trend_predictor_table
    import trend_predictor_table_pkg::*;
#(
    parameter int INDEX_WIDTH        = 6,
    parameter int STAT_COUNTER_WIDTH = 5
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          ready,
    input  logic                          pred_req,
    input  logic [31:0]                   pred_pc,
    output logic                          pred_vld,
    output logic                          pred_taken,
    output logic [CLS_W-1:0]              pred_class,
    input  logic                          upd_vld,
    input  logic [31:0]                   upd_pc,
    input  logic                          upd_taken,
    input  logic                          upd_mispredict,
    input  logic                          stat_clr,
    output logic [STAT_COUNTER_WIDTH-1:0] stat_count,
    output logic                          stat_of
);

    localparam int DEPTH = 1 << INDEX_WIDTH;
    localparam int STAT_SUM_W = STAT_COUNTER_WIDTH + 1;
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = '1;
    localparam logic [STAT_SUM_W-1:0] STAT_MAX = {1'b0, {STAT_COUNTER_WIDTH{1'b1}}};
    localparam logic [STAT_SUM_W-1:0] STAT_INC = STAT_SUM_W'(2);
    localparam logic [STAT_SUM_W-1:0] STAT_DEC = STAT_SUM_W'(1);

    state_t                  state;
    logic [INDEX_WIDTH-1:0]  walk_idx;
    logic [CNT_W-1:0]        table_q [DEPTH];

    logic [INDEX_WIDTH-1:0]  pred_idx;
    logic [INDEX_WIDTH-1:0]  upd_idx;
    logic                    run;
    logic                    req_en;
    logic                    upd_en;
    logic                    bypass;

    logic [CNT_W-1:0]        upd_rd;
    logic [CNT_W-1:0]        upd_new;
    logic [CLS_W-1:0]        upd_cls;
    logic [CNT_W-1:0]        lk_rd;
    logic [CNT_W-1:0]        lk_new;
    logic [CLS_W-1:0]        lk_cls;
    logic [CNT_W-1:0]        lk_count;
    logic [CLS_W-1:0]        lk_class;

    logic [STAT_SUM_W-1:0]   stat_sum;
    logic                    stat_hit_max;

    assign pred_idx = pred_pc[INDEX_WIDTH+1:2];
    assign upd_idx  = upd_pc[INDEX_WIDTH+1:2];
    assign run      = (state == ST_RUN);
    assign req_en   = run & pred_req;
    assign upd_en   = run & upd_vld;
    assign bypass   = upd_en & (upd_idx == pred_idx);

    assign upd_rd = table_q[upd_idx];
    assign lk_rd  = table_q[pred_idx];

    trend_step_unit u_upd_step (
        .count     (upd_rd),
        .down      (~upd_taken),
        .new_count (upd_new),
        .cls       (upd_cls)
    );

    // Same step as the update path; its result only matters when the indices collide
    trend_step_unit u_lk_step (
        .count     (lk_rd),
        .down      (~upd_taken),
        .new_count (lk_new),
        .cls       (lk_cls)
    );

    assign lk_count = bypass ? lk_new : lk_rd;
    assign lk_class = bypass ? class_of(lk_new) : lk_cls;

    logic unused_bits;
    assign unused_bits = ^{pred_pc[31:INDEX_WIDTH+2], pred_pc[1:0],
                           upd_pc[31:INDEX_WIDTH+2], upd_pc[1:0], upd_cls};

    always_comb begin
        stat_sum     = {1'b0, stat_count};
        stat_hit_max = 1'b0;
        if (upd_mispredict) begin
            stat_sum = stat_sum + STAT_INC;
            if (stat_sum > STAT_MAX) begin
                stat_sum     = STAT_MAX;
                stat_hit_max = 1'b1;
            end
        end else if (stat_count != '0) begin
            stat_sum = stat_sum - STAT_DEC;
        end
    end

    // Entries need no reset: the INIT walk clears every one before RUN
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            table_q[walk_idx] <= '0;
        end else if (upd_vld) begin
            table_q[upd_idx] <= upd_new;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            walk_idx   <= '0;
            ready      <= 1'b0;
            pred_vld   <= 1'b0;
            pred_taken <= 1'b0;
            pred_class <= '0;
            stat_count <= '0;
            stat_of    <= 1'b0;
        end else begin
            pred_vld <= req_en;
            if (req_en) begin
                pred_taken <= ~lk_count[CNT_W-1];
                pred_class <= lk_class;
            end

            if (state == ST_INIT) begin
                walk_idx <= walk_idx + 1'b1;
                if (walk_idx == LAST_IDX) begin
                    state <= ST_RUN;
                    ready <= 1'b1;
                end
            end

            if (stat_clr) begin
                stat_count <= '0;
                stat_of    <= 1'b0;
            end else if (upd_en) begin
                stat_count <= stat_sum[STAT_COUNTER_WIDTH-1:0];
                if (stat_hit_max) begin
                    stat_of <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_trend_predictor_table.sv
// tb/tb_trend_predictor_table.sv - directed self-checking bench for trend_predictor_table
module tb_trend_predictor_table;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready;
    logic        pred_req;
    logic [31:0] pred_pc;
    logic        pred_vld;
    logic        pred_taken;
    logic [3:0]  pred_class;
    logic        upd_vld;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        upd_mispredict;
    logic        stat_clr;
    logic [4:0]  stat_count;
    logic        stat_of;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    trend_predictor_table #(
        .INDEX_WIDTH        (6),
        .STAT_COUNTER_WIDTH (5)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .ready          (ready),
        .pred_req       (pred_req),
        .pred_pc        (pred_pc),
        .pred_vld       (pred_vld),
        .pred_taken     (pred_taken),
        .pred_class     (pred_class),
        .upd_vld        (upd_vld),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_mispredict (upd_mispredict),
        .stat_clr       (stat_clr),
        .stat_count     (stat_count),
        .stat_of        (stat_of)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic exp_taken, input logic [3:0] exp_cls);
        pred_req = 1'b1;
        pred_pc  = pc;
        tick();
        pred_req = 1'b0;
        check({tag, "/vld"}, pred_vld, 1);
        check({tag, "/taken"}, pred_taken, exp_taken);
        check({tag, "/class"}, pred_class, exp_cls);
    endtask

    task automatic update(input logic [31:0] pc, input logic taken, input logic mis);
        upd_vld        = 1'b1;
        upd_pc         = pc;
        upd_taken      = taken;
        upd_mispredict = mis;
        tick();
        upd_vld        = 1'b0;
    endtask

    task automatic walk(input string tag);
        for (int i = 1; i <= 63; i++) begin
            tick();
            check({tag, "/ready_lo"}, ready, 0);
            check({tag, "/vld_lo"}, pred_vld, 0);
        end
        tick();
        check({tag, "/ready_hi"}, ready, 1);
        check({tag, "/vld_last"}, pred_vld, 0);
        check({tag, "/stat_init"}, stat_count, 0);
    endtask

    initial begin
        rst_n          = 1'b0;
        pred_req       = 1'b0;
        pred_pc        = '0;
        upd_vld        = 1'b0;
        upd_pc         = '0;
        upd_taken      = 1'b0;
        upd_mispredict = 1'b0;
        stat_clr       = 1'b0;
        tick();
        tick();
        check("rst/ready", ready, 0);
        check("rst/vld", pred_vld, 0);
        check("rst/taken", pred_taken, 0);
        check("rst/class", pred_class, 0);
        check("rst/stat", stat_count, 0);
        check("rst/of", stat_of, 0);

        // Requests and updates during the walk must be ignored
        rst_n          = 1'b1;
        pred_req       = 1'b1;
        pred_pc        = 32'h40;
        upd_vld        = 1'b1;
        upd_pc         = 32'h40;
        upd_taken      = 1'b1;
        upd_mispredict = 1'b1;
        walk("walk1");
        pred_req       = 1'b0;
        upd_vld        = 1'b0;
        upd_mispredict = 1'b0;
        tick();
        check("idle/vld", pred_vld, 0);

        lookup("cleared", 32'h40, 1'b1, 4'b0100);

        update(32'h40, 1'b1, 1'b0);
        lookup("up_2", 32'h40, 1'b1, 4'b1100);
        update(32'h40, 1'b1, 1'b0);
        lookup("up_3", 32'h40, 1'b1, 4'b1000);
        update(32'h40, 1'b1, 1'b0);
        lookup("up_sat", 32'h40, 1'b1, 4'b1000);
        check("up/stat_floor", stat_count, 0);

        update(32'h44, 1'b0, 1'b0);
        lookup("dn_m3", 32'h44, 1'b0, 4'b0011);
        update(32'h44, 1'b0, 1'b0);
        lookup("dn_m4", 32'h44, 1'b0, 4'b0001);
        update(32'h44, 1'b1, 1'b0);
        lookup("dn_m2", 32'h44, 1'b0, 4'b0001);

        update(32'h48, 1'b1, 1'b0);
        update(32'h48, 1'b1, 1'b0);
        update(32'h48, 1'b0, 1'b0);
        lookup("dc_1", 32'h48, 1'b1, 4'b0010);
        update(32'h48, 1'b1, 1'b0);
        lookup("dc_2", 32'h48, 1'b1, 4'b1100);

        update(32'h4c, 1'b1, 1'b0);
        update(32'h4c, 1'b0, 1'b0);
        lookup("neg1", 32'h4c, 1'b0, 4'b0010);
        update(32'h4c, 1'b1, 1'b0);
        lookup("neg1_up", 32'h4c, 1'b1, 4'b0100);

        // Same-index lookup and update in one cycle
        pred_req  = 1'b1;
        pred_pc   = 32'h80;
        upd_vld   = 1'b1;
        upd_pc    = 32'h80;
        upd_taken = 1'b0;
        tick();
        pred_req  = 1'b0;
        upd_vld   = 1'b0;
        check("byp/vld", pred_vld, 1);
        check("byp/taken", pred_taken, 0);
        check("byp/class", pred_class, 4'b0011);
        lookup("byp_after", 32'h80, 1'b0, 4'b0011);

        pred_req  = 1'b1;
        pred_pc   = 32'h84;
        upd_vld   = 1'b1;
        upd_pc    = 32'h88;
        upd_taken = 1'b0;
        tick();
        pred_req  = 1'b0;
        upd_vld   = 1'b0;
        check("nobyp/taken", pred_taken, 1);
        check("nobyp/class", pred_class, 4'b0100);

        pred_req = 1'b1;
        pred_pc  = 32'h40;
        tick();
        check("b2b0/vld", pred_vld, 1);
        check("b2b0/class", pred_class, 4'b1000);
        pred_pc  = 32'h44;
        tick();
        pred_req = 1'b0;
        check("b2b1/vld", pred_vld, 1);
        check("b2b1/taken", pred_taken, 0);
        check("b2b1/class", pred_class, 4'b0001);
        tick();
        check("b2b/vld_drop", pred_vld, 0);

        for (int i = 1; i <= 16; i++) begin
            update(32'hc0, 1'b1, 1'b1);
            if (i == 15) begin
                check("stat/30", stat_count, 30);
                check("stat/of_lo", stat_of, 0);
            end
        end
        check("stat/31", stat_count, 31);
        check("stat/of_hi", stat_of, 1);
        for (int i = 1; i <= 40; i++) begin
            update(32'hc0, 1'b1, 1'b0);
        end
        check("stat/zero", stat_count, 0);
        check("stat/of_sticky", stat_of, 1);
        update(32'hc0, 1'b1, 1'b1);
        check("stat/2", stat_count, 2);
        stat_clr = 1'b1;
        update(32'hc0, 1'b1, 1'b1);
        stat_clr = 1'b0;
        check("clr/stat", stat_count, 0);
        check("clr/of", stat_of, 0);

        // Asynchronous reset drops a pending response
        pred_req = 1'b1;
        pred_pc  = 32'h40;
        tick();
        pred_req = 1'b0;
        check("mid/vld_before", pred_vld, 1);
        rst_n = 1'b0;
        #1;
        check("mid/vld_drop", pred_vld, 0);
        check("mid/ready", ready, 0);
        tick();
        rst_n = 1'b1;
        walk("walk2");
        lookup("rewalk", 32'h40, 1'b1, 4'b0100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/trend_predictor_table.md
# trend_predictor_table

Direction-prediction table built from 3-bit trend counters with an accuracy statistic. Fetch sends prediction lookups; execute sends branch-resolution updates. The table sits between the fetch-stage PC and the branch resolution unit. After reset, a walk clears every entry, and lookups return a registered prediction one cycle after request.

## Interface
- INDEX_WIDTH, 6: table has 2^INDEX_WIDTH entries, indexed by pc[INDEX_WIDTH+1:2].
- STAT_COUNTER_WIDTH, 5: width of the misprediction statistic counter (minimum 3).
- clk, in, 1: sole clock, rising edge.
- rst_n, in, 1: reset, asynchronous and active-low.
- ready, out, 1: high in RUN state only.
- pred_req, in, 1: lookup request.
- pred_pc, in, 32: lookup PC.
- pred_vld, out, 1: response valid, one cycle after an accepted pred_req.
- pred_taken, out, 1: predicted direction (1 = taken).
- pred_class, out, 4: decoded class {high_conf, upward, downward, no_conf}.
- upd_vld, in, 1: resolution update.
- upd_pc, in, 32: resolved branch PC.
- upd_taken, in, 1: actual direction.
- upd_mispredict, in, 1: fetch prediction was wrong.
- stat_clr, in, 1: synchronous clear of the statistic and the sticky overflow.
- stat_count, out, STAT_COUNTER_WIDTH: misprediction score.
- stat_of, out, 1: sticky; set when a stat increment hits the upper clamp.

## Operation
- **Counter encoding:** 3-bit two's complement, range -4..3.
- **Prediction:** pred_taken = ~count[2].
- **Class decode.** A count may fall in more than one class, so pred_class is not one-hot.
  - high_conf: {3, 2}.
  - upward: {0, 2}.
  - downward: {1, -1, -3}.
  - no_conf: {-4, -3, -2}.
- **Update step.** down = ~upd_taken. Step B is chosen by class, in this priority order:
  - upward: down ? -3 : +2.
  - else downward: down ? -2 : +1.
  - else: down ? -2 : +2.
- **Update arithmetic:** new = count + B, computed at 4-bit signed width, then clamped to [-4, 3].
- **FSM states:** INIT and RUN.
  - INIT is entered on reset. A walk index writes 3'b000 to one entry per cycle, from 0 to 2^INDEX_WIDTH-1.
  - After the last entry is written, the FSM moves to RUN.
  - In INIT, ready=0 and pred_req and upd_vld are ignored (no response, no write, no stat change).
- **Statistic.** Applied on each accepted upd_vld:
  - upd_mispredict=1: add +2.
  - upd_mispredict=0: add -1.
  - Result is clamped to [0, 2^STAT_COUNTER_WIDTH-1].
  - If the +2 result would exceed the maximum, stat_of is set.
  - stat_clr has priority over the same-cycle update: both stat_count and stat_of become 0.
- **Same-index bypass:** an update and a lookup in the same cycle to the same index make the response reflect the updated count.

## Timing
- **Reset values:** ready=0, pred_vld=0, pred_taken=0, pred_class=0, stat_count=0, stat_of=0, FSM=INIT, walk index=0.
- INIT lasts exactly 2^INDEX_WIDTH cycles after rst_n deasserts. ready rises on the following cycle.
- **Lookup latency:** pred_req sampled at edge N gives pred_vld/pred_taken/pred_class valid after edge N, for one cycle only.
- **Throughput:** back-to-back requests are accepted, one per cycle. No stall exists.
- **Update timing:** the write occurs at the sampling edge. A lookup in the next cycle sees the new value.
- **Reset mid-operation:** an asynchronous clear of all state returns the FSM to INIT and restarts the walk at 0. A pending response is dropped.

## Structure
- **Shared package:** counter width (3), the class encodings, the step constants (+2, +1, -2, -3), the clamp bounds, and the INIT/RUN state encoding. These are shared with other predictor blocks.
- **Sub-module:** trend_step_unit, combinational. It takes count and down and produces new count plus the 4-bit class. It is instantiated twice: once on the update path and once on the lookup decode/bypass path.
- The table is a flat register array. It needs no reset, because the walk initialises it.

## Test plan
- **Reset walk:** with INDEX_WIDTH=6, assert reset, then release. Expect ready=0 for 64 cycles, then 1. Any lookup then returns pred_taken=1 and pred_class=0100.
- **Upward saturation:** three taken updates at pc 0x40. The entry goes 0 -> 2 -> 3 -> 3. A lookup returns class 1000.
- **Downward path:** from 0, not-taken gives -3 (class 0011). Not-taken again gives -4 via -2 with clamp (class 0001). Taken gives -2.
- **Downward-class step:** preload 1, update taken. Expect 2 (class 1100).
- **Bypass:** same-cycle lookup and not-taken update at pc 0x80, with the entry at 0. The response is pred_taken=0 and class 0011.
- **Statistic:**
  - 16 mispredicts with width 5: stat_count reaches 31 and stat_of=1.
  - Then 40 correct updates: stat_count reaches 0 and stat_of stays 1.
  - stat_clr then clears both.
